// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: generic control-bundle pipeline register.
// Carries {valid, ctrl} through STAGES registers with stall (hold), flush
// (bubble insertion into the youngest FLUSH_STAGES stages) and input gating.
// Occupancy is a registered popcount of the stage valid bits.
module ctrl_pipe_stage #(
    parameter int                WIDTH        = 8,
    parameter int                STAGES       = 1,
    parameter int                FLUSH_STAGES = 1,
    parameter logic [WIDTH-1:0]  BUBBLE_VAL   = '0,
    localparam int               OCC_W        = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_ctrl,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    // Stage 0 is the youngest entry, stage STAGES-1 drives the outputs.
    logic [STAGES-1:0]            vld_q, vld_d, src_vld;
    logic [STAGES-1:0][WIDTH-1:0] ctrl_q, ctrl_d, src_ctrl;
    logic [OCC_W-1:0]             occ_q, occ_d;
    logic                         flush_en;

    // A flush with zero flushable stages is a no-op.
    assign flush_en = flush && (FLUSH_STAGES > 0);

    // Advance source for each stage: gated input for stage 0, the older
    // neighbour otherwise. Built in generate so STAGES=1 needs no slicing.
    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_src
            if (g == 0) begin : g_head
                assign src_vld[g]  = in_valid;
                assign src_ctrl[g] = in_valid ? in_ctrl : BUBBLE_VAL;
            end else begin : g_body
                assign src_vld[g]  = vld_q[g-1];
                assign src_ctrl[g] = ctrl_q[g-1];
            end
        end
    endgenerate

    // Per-stage next state: flush beats stall beats advance; the stage just
    // past the flush window loses its source, so it becomes a bubble unless
    // stalled.
    always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        occ_d  = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (flush_en && (i < FLUSH_STAGES)) begin
                vld_d[i]  = 1'b0;
                ctrl_d[i] = BUBBLE_VAL;
            end else if (flush_en && (i == FLUSH_STAGES)) begin
                if (!stall) begin
                    vld_d[i]  = 1'b0;
                    ctrl_d[i] = BUBBLE_VAL;
                end
            end else if (!stall) begin
                vld_d[i]  = src_vld[i];
                ctrl_d[i] = src_ctrl[i];
            end
        end
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCC_W'(vld_d[i]);
        end
    end

    // Stage and occupancy registers; synchronous reset empties the pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            ctrl_q <= {STAGES{BUBBLE_VAL}};
            occ_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
            occ_q  <= occ_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_ctrl  = ctrl_q[STAGES-1];
    assign occupancy = occ_q;

endmodule
